// File: rtl/edsac_timing_pkg.sv
// Shared EDSAC timing constants: minor-cycle geometry and digit positions.
package edsac_timing_pkg;

    localparam int unsigned EDSAC_MC_LEN   = 36;  // pulse intervals per minor cycle
    localparam int unsigned EDSAC_HALF_LEN = 18;  // pulse intervals per short word
    localparam int unsigned PI_D0          = 0;   // digit position marked by d0
    localparam int unsigned PI_LEN_FLAG    = 1;   // order bit carrying the length flag

    // Width of a counter that spans 0..len-1.
    function automatic int unsigned pi_width(input int unsigned len);
        return (len > 1) ? $clog2(len) : 1;
    endfunction

endpackage

// File: rtl/pi_counter.sv
// Pulse-interval phase counter with sticky d0 phase checking; shared by all tanks.
module pi_counter
    import edsac_timing_pkg::*;
#(
    parameter int unsigned MC_LEN  = EDSAC_MC_LEN,
    parameter int unsigned PHASE_W = pi_width(MC_LEN)
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               d0_i,
    output logic [PHASE_W-1:0] phase_o,    // p.i. of the current cycle
    output logic               sync_err_o
);

    localparam logic [PHASE_W-1:0] Last = PHASE_W'(MC_LEN - 1);

    logic [PHASE_W-1:0] cnt_q, cnt_d;
    logic               armed_q, armed_d;
    logic               err_q, err_d;

    // Next count and error; the register holds the previous cycle's p.i.,
    // so the next count is also the phase of the cycle in progress.
    always_comb begin
        cnt_d   = (d0_i || cnt_q == Last) ? PHASE_W'(PI_D0) : cnt_q + 1'b1;
        // The first d0 after reset only establishes phase; it cannot be wrong.
        armed_d = armed_q | d0_i;
        err_d   = err_q | (d0_i & armed_q & (cnt_q != Last));
    end

    // Counter, arming flag and sticky error registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q   <= '0;
            armed_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            armed_q <= armed_d;
            err_q   <= err_d;
        end
    end

    assign phase_o    = cnt_d;
    assign sync_err_o = err_q;

endmodule

// File: rtl/order_tank.sv
// Order tank: one minor cycle of recirculating serial order storage, loaded from
// memory under the Coincidence Unit gate, with a parallel image of the short word.
module order_tank
    import edsac_timing_pkg::*;
#(
    parameter int unsigned MC_LEN   = EDSAC_MC_LEN,
    parameter int unsigned HALF_LEN = EDSAC_HALF_LEN
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                mem_in,
    input  logic                cu_gate_pos,
    input  logic                d0,
    input  logic                clr,
    output logic                order,
    output logic                f1_neg,
    output logic [HALF_LEN-1:0] order_word,
    output logic                loaded,
    output logic                sync_err
);

    localparam int unsigned PHASE_W = pi_width(MC_LEN);

    logic [PHASE_W-1:0]  phase;
    logic [MC_LEN-1:0]   loop_q, loop_d;
    logic [HALF_LEN-1:0] word_q, word_d;
    logic                f1_q, f1_d;
    logic                gate_q;
    logic                loaded_q, loaded_d;
    logic                in_bit;

    pi_counter #(
        .MC_LEN  (MC_LEN),
        .PHASE_W (PHASE_W)
    ) u_pi_counter (
        .clk_i      (clk),
        .rst_i      (rst),
        .d0_i       (d0),
        .phase_o    (phase),
        .sync_err_o (sync_err)
    );

    // Loop shift/load, short-word capture and length flag; clr overrides all.
    always_comb begin
        in_bit = cu_gate_pos ? mem_in : loop_q[0];
        loop_d = {in_bit, loop_q[MC_LEN-1:1]};
        word_d = word_q;
        f1_d   = f1_q;
        if (cu_gate_pos) begin
            for (int k = 0; k < int'(HALF_LEN); k++) begin
                if (phase == PHASE_W'(k)) begin
                    word_d[k] = mem_in;
                end
            end
            if (phase == PHASE_W'(PI_LEN_FLAG)) begin
                f1_d = ~mem_in;
            end
        end
        if (clr) begin
            loop_d = '0;
            word_d = '0;
            f1_d   = 1'b1;
        end
        // Load completes on the cycle the gate is first seen low.
        loaded_d = gate_q & ~cu_gate_pos;
    end

    // State registers; reset also drops any half-finished load.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            loop_q   <= '0;
            word_q   <= '0;
            f1_q     <= 1'b1;
            gate_q   <= 1'b0;
            loaded_q <= 1'b0;
        end else begin
            loop_q   <= loop_d;
            word_q   <= word_d;
            f1_q     <= f1_d;
            gate_q   <= cu_gate_pos;
            loaded_q <= loaded_d;
        end
    end

    assign order      = loop_q[0];
    assign f1_neg     = f1_q;
    assign order_word = word_q;
    assign loaded     = loaded_q;

endmodule

// File: tb/tb_order_tank.sv
// Self-checking bench for order_tank: cycle-level reference model plus
// table-driven loads and hand-written corner sequences.
module tb_order_tank;
    import edsac_timing_pkg::*;

    localparam int MC = EDSAC_MC_LEN;
    localparam int HL = EDSAC_HALF_LEN;

    logic          clk = 1'b0;
    logic          rst;
    logic          mem_in, cu_gate_pos, d0, clr;
    logic          order, f1_neg, loaded, sync_err;
    logic [HL-1:0] order_word;

    order_tank #(
        .MC_LEN   (MC),
        .HALF_LEN (HL)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .mem_in      (mem_in),
        .cu_gate_pos (cu_gate_pos),
        .d0          (d0),
        .clr         (clr),
        .order       (order),
        .f1_neg      (f1_neg),
        .order_word  (order_word),
        .loaded      (loaded),
        .sync_err    (sync_err)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: the tank is a ring indexed by absolute cycle mod MC_LEN;
    // phase is cycles elapsed since the last d0 (reset acts as a d0 one cycle early).
    logic          ring [MC];
    logic [HL-1:0] m_word;
    logic          m_f1, m_loaded, m_err, m_gate_prev, m_seen;
    int            m_cyc, m_last;

    int   ph;        // drive-side p.i. schedule for d0
    int   n_loaded;  // loaded pulses observed
    logic rg;

    typedef struct {
        logic [HL-1:0] word;
        logic [HL-1:0] exp_word;
        logic          exp_f1;
    } ld_vec_t;

    ld_vec_t tbl [6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < MC; i++) ring[i] = 1'b0;
        m_word      = '0;
        m_f1        = 1'b1;
        m_loaded    = 1'b0;
        m_err       = 1'b0;
        m_gate_prev = 1'b0;
        m_seen      = 1'b0;
        m_cyc       = 0;
        m_last      = -1;
    endtask

    task automatic model_step(input logic g, input logic m, input logic d, input logic c);
        int phase;
        if (d) begin
            if (m_seen && ((m_cyc - m_last) % MC) != 0) m_err = 1'b1;
            m_seen = 1'b1;
            m_last = m_cyc;
        end
        phase = (m_cyc - m_last) % MC;
        if (c) begin
            for (int i = 0; i < MC; i++) ring[i] = 1'b0;
            m_word = '0;
            m_f1   = 1'b1;
        end else if (g) begin
            ring[m_cyc % MC] = m;
            if (phase < HL) m_word[phase] = m;
            if (phase == 1) m_f1 = ~m;
        end
        m_loaded    = m_gate_prev & ~g;
        m_gate_prev = g;
        m_cyc++;
    endtask

    // One clock: drive at posedge+1, check all outputs at negedge, advance model.
    task automatic cycle(input logic g, input logic m, input logic c, input logic extra_d0);
        cu_gate_pos = g;
        mem_in      = m;
        clr         = c;
        d0          = (ph == 0) | extra_d0;
        @(negedge clk);
        chk("order",      32'(order),      32'(ring[m_cyc % MC]));
        chk("order_word", 32'(order_word), 32'(m_word));
        chk("f1_neg",     32'(f1_neg),     32'(m_f1));
        chk("loaded",     32'(loaded),     32'(m_loaded));
        chk("sync_err",   32'(sync_err),   32'(m_err));
        if (loaded) n_loaded++;
        @(posedge clk);
        model_step(g, m, d0, c);
        ph = (ph + 1) % MC;
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        chk("rst_order",      32'(order),      32'd0);
        chk("rst_order_word", 32'(order_word), 32'd0);
        chk("rst_f1_neg",     32'(f1_neg),     32'd1);
        chk("rst_loaded",     32'(loaded),     32'd0);
        chk("rst_sync_err",   32'(sync_err),   32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        ph = 0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'($urandom), 1'b0, 1'b0);
    endtask

    // Wait for p.i. 0 then gate in a short word; optionally clr on its last bit.
    task automatic load_word(input logic [HL-1:0] w, input logic clr_last);
        while (ph != 0) cycle(1'b0, 1'($urandom), 1'b0, 1'b0);
        for (int i = 0; i < HL; i++) cycle(1'b1, w[i], clr_last && (i == HL - 1), 1'b0);
    endtask

    initial begin
        logic [HL-1:0] w;
        tbl[0] = '{word: 18'h2A5B5, exp_word: 18'h2A5B5, exp_f1: 1'b1};
        tbl[1] = '{word: 18'h00002, exp_word: 18'h00002, exp_f1: 1'b0};
        tbl[2] = '{word: 18'h3FFFF, exp_word: 18'h3FFFF, exp_f1: 1'b0};
        tbl[3] = '{word: 18'h00000, exp_word: 18'h00000, exp_f1: 1'b1};
        tbl[4] = '{word: 18'h2AAAA, exp_word: 18'h2AAAA, exp_f1: 1'b0};
        tbl[5] = '{word: 18'h15555, exp_word: 18'h15555, exp_f1: 1'b1};

        mem_in = 1'b0; cu_gate_pos = 1'b0; d0 = 1'b0; clr = 1'b0;
        ph = 0;
        model_reset();
        do_reset();

        // Table-driven loads: word image, length flag, exactly one loaded pulse.
        foreach (tbl[i]) begin
            n_loaded = 0;
            load_word(tbl[i].word, 1'b0);
            idle(2);
            chk("tbl_word", 32'(order_word), 32'(tbl[i].exp_word));
            chk("tbl_f1",   32'(f1_neg),     32'(tbl[i].exp_f1));
            idle(MC - 2);
            chk("tbl_loaded_count", 32'(n_loaded), 32'd1);
        end

        // Serial pattern repeats unchanged for three minor cycles after a load.
        w = 18'h2A5B5;
        cycle(1'b0, 1'b0, 1'b1, 1'b0);
        load_word(w, 1'b0);
        while (ph != 0) cycle(1'b0, 1'($urandom), 1'b0, 1'b0);
        for (int i = 0; i < 3 * MC; i++) begin
            // Check the bit about to be presented at p.i. ph.
            chk("pattern", 32'(order), (ph < HL) ? 32'(w[ph]) : 32'd0);
            cycle(1'b0, 1'($urandom), 1'b0, 1'b0);
        end

        // clr coincident with the gate wins over the load.
        load_word(18'h3FFFF, 1'b1);
        chk("clr_word", 32'(order_word), 32'd0);
        chk("clr_f1",   32'(f1_neg),     32'd1);
        for (int i = 0; i < MC; i++) begin
            chk("clr_order", 32'(order), 32'd0);
            cycle(1'b0, 1'($urandom), 1'b0, 1'b0);
        end

        // Gate held open well beyond one minor cycle: newest bits overwrite.
        for (int i = 0; i < 80; i++) cycle(1'b1, 1'($urandom), 1'b0, 1'b0);
        idle(MC + 4);

        // Randomised gate runs, data and occasional clr against the model.
        rg = 1'b0;
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(7) == 0) rg = ~rg;
            cycle(rg, 1'($urandom), ($urandom_range(49) == 0), 1'b0);
        end
        chk("no_false_sync_err", 32'(sync_err), 32'd0);

        // Spurious d0 at p.i. 30 sets the sticky phase error.
        while (ph != 30) cycle(1'b0, 1'($urandom), 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 1'b0, 1'b1);
        chk("sync_err_set", 32'(sync_err), 32'd1);
        idle(40);
        chk("sync_err_sticky", 32'(sync_err), 32'd1);

        // Reset in the middle of a load: reset values, no loaded pulse.
        do_reset();
        while (ph != 0) cycle(1'b0, 1'($urandom), 1'b0, 1'b0);
        for (int i = 0; i < 9; i++) cycle(1'b1, 1'b1, 1'b0, 1'b0);
        cu_gate_pos = 1'b1;
        mem_in      = 1'b1;
        n_loaded    = 0;
        do_reset();
        idle(40);
        chk("rst_mid_load_no_pulse", 32'(n_loaded),   32'd0);
        chk("rst_mid_load_word",     32'(order_word), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/order_tank.md
ORDER_TANK -- requirements
Module: order_tank

Interface
REQ-001 SHALL have parameter MC_LEN, default 36, pulse intervals (p.i.) per minor cycle.
REQ-002 SHALL have parameter HALF_LEN, default 18, p.i. per short-word half-cycle.
REQ-003 SHALL have port clk  input  1  p.i. clock, all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port mem_in  input  1  serial bit from selected Memory Tank output, LSB first.
REQ-006 SHALL have port cu_gate_pos  input  1  Coincidence Unit gate; high = accept memory data.
REQ-007 SHALL have port d0  input  1  digit pulse marking p.i. 0 of each minor cycle.
REQ-008 SHALL have port clr  input  1  synchronous clear of stored order.
REQ-009 SHALL have port order  output  1  recirculating serial order bit, to Coincidence Unit.
REQ-010 SHALL have port f1_neg  output  1  inverted order bit 1 (length flag), to Coincidence Unit.
REQ-011 SHALL have port order_word  output  HALF_LEN  parallel image of last loaded short word.
REQ-012 SHALL have port loaded  output  1  one-cycle pulse when a load completes.
REQ-013 SHALL have port sync_err  output  1  sticky d0 phase error flag.

Function
REQ-014 SHALL hold a MC_LEN-stage serial loop; order = loop stage 0 each cycle.
REQ-015 SHALL each cycle shift the loop one stage; input stage takes mem_in when cu_gate_pos=1, else current stage 0 bit (recirculate).
REQ-016 SHALL therefore re-present any bit exactly MC_LEN cycles after entry, same p.i. phase.
REQ-017 SHALL keep a phase counter 0..MC_LEN-1: load 0 when d0=1, else increment, wrap MC_LEN-1 -> 0.
REQ-018 SHALL set sync_err when d0=1 and counter /= MC_LEN-1 (counter not at wrap); cleared only by rst.
REQ-019 SHALL, when cu_gate_pos=1 and phase k < HALF_LEN, write mem_in into order_word[k] in that cycle.
REQ-020 SHALL, when cu_gate_pos=1 and phase = 1, set f1_neg <= ~mem_in; otherwise hold f1_neg.
REQ-021 SHALL pulse loaded for exactly one cycle, the cycle after cu_gate_pos falls 1->0.
REQ-022 SHALL on clr=1 zero loop and order_word, set f1_neg=1, clr taking priority over load and shift.
REQ-023 SHALL not alter phase counter or sync_err on clr.
REQ-024 SHALL on gate open longer than MC_LEN cycles keep loading; newest bit overwrites (no error).
REQ-025 SHALL treat cu_gate_pos and d0 coincident in one cycle as: counter -> 0 and bit loaded at phase 0.
REQ-026 SHALL have zero-cycle combinational path from loop stage 0 to order; all else registered.

Reset
REQ-027 SHALL on rst=1 clear loop, order_word, counter to 0, sync_err=0, loaded=0, f1_neg=1, immediately and asynchronously.
REQ-028 SHALL after rst release require a d0 before sync_err checking is meaningful; first d0 SHALL NOT set sync_err.
REQ-029 SHALL abandon any in-progress load on rst; no loaded pulse produced.

Structure
REQ-030 SHALL take MC_LEN, HALF_LEN and digit-position constants from shared package edsac_timing_pkg.
REQ-031 SHALL implement phase counter and sync check as sub-module pi_counter, reusable by other tanks.

Verification
REQ-032 Load 18-bit word 0x2A5B5 during gate p.i. 0..17 -> order_word=0x2A5B5, loaded pulse one cycle after gate fall.
REQ-033 After load, no gate for 3 minor cycles -> order reproduces same 36-bit serial pattern every 36 cycles.
REQ-034 Load with bit at p.i. 1 = 1 -> f1_neg=0; reload with bit 1 = 0 -> f1_neg=1.
REQ-035 d0 every 36 cycles then one d0 at cycle 30 of a cycle -> sync_err=1 and stays 1 until rst.
REQ-036 clr asserted together with cu_gate_pos -> loop and order_word zero, f1_neg=1, next order bits 0.
REQ-037 rst pulsed mid-load (p.i. 9) -> all outputs at reset values, no loaded pulse, order_word=0.
